// File: rtl/simple16_trace_buf.sv
// Trace buffer for the simple16_cpu observation port: captures register-write events into a FWFT FIFO.
// Optional shadow register file (shadow_raddr/shadow_rdata) is enabled with SIMPLE16_TRACE_SHADOW_EN.
module simple16_trace_buf #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   obs_pc,
  input  logic          obs_reg_we,
  input  logic [2:0]    obs_reg_waddr,
  input  logic [15:0]   obs_reg_wdata,
  input  logic          arm,
  input  logic          clear,
  input  logic          trig_en,
  input  logic [15:0]   trig_pc,
  input  logic [15:0]   max_events,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [15:0]   m_pc,
  output logic [2:0]    m_waddr,
  output logic [15:0]   m_wdata,
  output logic [1:0]    state,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   cap_cnt
`ifdef SIMPLE16_TRACE_SHADOW_EN
  ,
  input  logic [2:0]    shadow_raddr,
  output logic [15:0]   shadow_rdata
`endif
);

  // state | meaning
  // IDLE  | no session; waiting for arm
  // ARMED | waiting for obs_pc == trig_pc
  // RUN   | capturing events into the FIFO
  // DONE  | capture limit reached; draining only
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [15:0]   mem_pc   [DEPTH];
  logic [2:0]    mem_addr [DEPTH];
  logic [15:0]   mem_data [DEPTH];

  logic          empty, full;
  logic          trig_hit, evt;
  logic          do_push, do_pop, do_drop;
  logic          limit_hit;
  logic [15:0]   cap_next;
  logic [AW-1:0] rd_idx;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign trig_hit = (state_q == ARMED) && (obs_pc == trig_pc);
  assign evt      = obs_reg_we && ((state_q == RUN) || trig_hit);

  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign do_pop    = !empty && m_ready;
  assign do_push   = evt && (!full || do_pop);
  assign do_drop   = evt && full && !do_pop;
  assign cap_next  = (cap_cnt == 16'hFFFF) ? cap_cnt : cap_cnt + 16'd1;
  assign limit_hit = do_push && (max_events != 16'd0) && (cap_next == max_events);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = trig_en ? ARMED : RUN;
      ARMED:   if (trig_hit) state_d = limit_hit ? DONE : RUN;
      RUN:     if (limit_hit) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
      cap_cnt  <= 16'd0;
    end else if (clear) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
      cap_cnt  <= 16'd0;
    end else begin
      state_q <= state_d;
      if (do_push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        cap_cnt <= cap_next;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem_pc[wr_ptr[AW-1:0]]   <= obs_pc;
      mem_addr[wr_ptr[AW-1:0]] <= obs_reg_waddr;
      mem_data[wr_ptr[AW-1:0]] <= obs_reg_wdata;
    end
  end

  assign rd_idx  = rd_ptr[AW-1:0];
  assign m_valid = !empty;
  assign m_pc    = m_valid ? mem_pc[rd_idx]   : 16'd0;
  assign m_waddr = m_valid ? mem_addr[rd_idx] : 3'd0;
  assign m_wdata = m_valid ? mem_data[rd_idx] : 16'd0;
  assign state   = state_q;
  assign count   = wr_ptr - rd_ptr;

`ifdef SIMPLE16_TRACE_SHADOW_EN
  logic [15:0] shadow [8];

  // Mirrors every CPU register write regardless of capture state or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) shadow[i] <= 16'd0;
    end else if (obs_reg_we) begin
      shadow[obs_reg_waddr] <= obs_reg_wdata;
    end
  end

  assign shadow_rdata = shadow[shadow_raddr];
`endif

endmodule

// File: tb/tb_simple16_trace_buf.sv
// Scoreboard bench for simple16_trace_buf: directed scenarios plus a randomized phase against a queue model.
module tb_simple16_trace_buf;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   obs_pc;
  logic          obs_reg_we;
  logic [2:0]    obs_reg_waddr;
  logic [15:0]   obs_reg_wdata;
  logic          arm, clear, trig_en;
  logic [15:0]   trig_pc, max_events;
  logic          m_valid, m_ready;
  logic [15:0]   m_pc, m_wdata;
  logic [2:0]    m_waddr;
  logic [1:0]    state;
  logic [AW:0]   count;
  logic          overflow;
  logic [15:0]   drop_cnt, cap_cnt;
`ifdef SIMPLE16_TRACE_SHADOW_EN
  logic [2:0]    shadow_raddr;
  logic [15:0]   shadow_rdata;
  logic [15:0]   shadow_model [8];
`endif

  simple16_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .obs_pc(obs_pc), .obs_reg_we(obs_reg_we),
    .obs_reg_waddr(obs_reg_waddr), .obs_reg_wdata(obs_reg_wdata),
    .arm(arm), .clear(clear), .trig_en(trig_en), .trig_pc(trig_pc),
    .max_events(max_events), .m_valid(m_valid), .m_ready(m_ready),
    .m_pc(m_pc), .m_waddr(m_waddr), .m_wdata(m_wdata), .state(state),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .cap_cnt(cap_cnt)
`ifdef SIMPLE16_TRACE_SHADOW_EN
    , .shadow_raddr(shadow_raddr), .shadow_rdata(shadow_rdata)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t sbq[$];
  int   m_mode;     // 0 idle, 1 waiting for trigger, 2 capturing, 3 finished
  int   m_occ, m_cap, m_drop;
  bit   m_ovf;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    m_mode = 0; m_occ = 0; m_cap = 0; m_drop = 0; m_ovf = 0;
  endtask

  // Reference behaviour for one rising edge, computed from the current inputs.
  task automatic model_edge();
    bit pop, hit, room;
    ent_t e;
`ifdef SIMPLE16_TRACE_SHADOW_EN
    if (obs_reg_we) shadow_model[obs_reg_waddr] = obs_reg_wdata;
`endif
    if (clear) begin
      model_reset();
      return;
    end
    pop  = (m_occ > 0) && m_ready;
    hit  = (m_mode == 1) && (obs_pc == trig_pc);
    room = (m_occ - int'(pop)) < DEPTH;
    if (obs_reg_we && (m_mode == 2 || hit)) begin
      if (room) begin
        e.pc = obs_pc; e.a = obs_reg_waddr; e.d = obs_reg_wdata;
        sbq.push_back(e);
        m_occ++;
        if (m_cap < 65535) m_cap++;
        if (max_events != 0 && m_cap == int'(max_events)) m_mode = 3;
        else if (hit) m_mode = 2;
      end else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
        if (hit) m_mode = 2;
      end
    end else if (hit) begin
      m_mode = 2;
    end else if (m_mode == 0 && arm) begin
      m_mode = trig_en ? 1 : 2;
    end
    if (pop) m_occ--;
  endtask

  task automatic tick(input bit we, input logic [15:0] pc, input logic [2:0] a,
                      input logic [15:0] d, input bit rdy, input bit a_arm, input bit clr);
    obs_reg_we = we; obs_pc = pc; obs_reg_waddr = a; obs_reg_wdata = d;
    m_ready = rdy; arm = a_arm; clear = clr;
`ifdef SIMPLE16_TRACE_SHADOW_EN
    shadow_raddr = 3'($urandom_range(0, 7));
`endif
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(0, 16'h0, 3'd0, 16'h0, rdy, 0, 0);
  endtask

  task automatic rand_evt(input bit rdy);
    tick(1, 16'($urandom), 3'($urandom), 16'($urandom), rdy, 0, 0);
  endtask

  // Monitor: compares the presented head against the scoreboard and status against the model.
  always @(negedge clk) begin
    ent_t e;
    check("count", int'(count), m_occ);
    check("state", int'(state), m_mode);
    check("cap_cnt", int'(cap_cnt), m_cap);
    check("drop_cnt", int'(drop_cnt), m_drop);
    check("overflow", int'(overflow), int'(m_ovf));
    check("m_valid", int'(m_valid), int'(m_occ > 0));
`ifdef SIMPLE16_TRACE_SHADOW_EN
    check("shadow_rdata", int'(shadow_rdata), int'(shadow_model[shadow_raddr]));
`endif
    if (m_valid) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sbq[0];
        check("m_pc", int'(m_pc), int'(e.pc));
        check("m_waddr", int'(m_waddr), int'(e.a));
        check("m_wdata", int'(m_wdata), int'(e.d));
        if (m_ready && rst_n) void'(sbq.pop_front());
      end
    end else begin
      check("empty_fields", int'(m_pc) + int'(m_waddr) + int'(m_wdata), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; obs_pc = 0; obs_reg_we = 0; obs_reg_waddr = 0; obs_reg_wdata = 0;
    arm = 0; clear = 0; trig_en = 0; trig_pc = 0; max_events = 0; m_ready = 0;
`ifdef SIMPLE16_TRACE_SHADOW_EN
    shadow_raddr = 0;
    for (int i = 0; i < 8; i++) shadow_model[i] = 16'h0;
`endif
    model_reset();
    #12;
    check("rst_state", int'(state), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_count", int'(count), 0);
    #10 rst_n = 1;
    @(posedge clk); #1;

    // Untriggered capture, immediate drain
    tick(0, 0, 0, 0, 1, 1, 0);
    tick(1, 16'h0004, 3'd1, 16'h0005, 1, 0, 0);
    tick(1, 16'h0005, 3'd2, 16'h000A, 1, 0, 0);
    tick(1, 16'h0006, 3'd3, 16'h000F, 1, 0, 0);
    idle(2, 1);
    check("t1_cap_cnt", int'(cap_cnt), 3);
    check("t1_state", int'(state), 2);
    check("t1_drained", sbq.size(), 0);
    tick(0, 0, 0, 0, 1, 0, 1);

    // PC trigger, inclusive of the matching cycle
    trig_en = 1; trig_pc = 16'h0010;
    tick(0, 0, 0, 0, 1, 1, 0);
    tick(1, 16'h000E, 3'd4, 16'h1111, 1, 0, 0);
    check("t2_armed_e", int'(state), 1);
    tick(1, 16'h000F, 3'd5, 16'h2222, 1, 0, 0);
    check("t2_armed_f", int'(state), 1);
    tick(1, 16'h0010, 3'd6, 16'h3333, 1, 0, 0);
    check("t2_run", int'(state), 2);
    tick(1, 16'h0011, 3'd7, 16'h4444, 1, 0, 0);
    idle(2, 1);
    check("t2_cap_cnt", int'(cap_cnt), 2);
    tick(0, 0, 0, 0, 1, 0, 1);
    trig_en = 0;

    // Overflow with stalled consumer, then drain in order
    tick(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) rand_evt(0);
    check("t3_count", int'(count), 16);
    check("t3_overflow", int'(overflow), 1);
    check("t3_drop_cnt", int'(drop_cnt), 4);
    idle(20, 1);
    check("t3_drained", sbq.size(), 0);
    tick(0, 0, 0, 0, 1, 0, 1);

    // Full FIFO with simultaneous push and pop
    tick(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) rand_evt(0);
    for (int i = 0; i < 8; i++) rand_evt(1);
    check("t4_count", int'(count), 16);
    check("t4_drop_cnt", int'(drop_cnt), 0);
    idle(20, 1);
    tick(0, 0, 0, 0, 1, 0, 1);

    // Event limit
    max_events = 16'd2;
    tick(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) rand_evt(0);
    check("t5_state", int'(state), 3);
    check("t5_count", int'(count), 2);
    check("t5_drop_cnt", int'(drop_cnt), 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    check("t5_rearm", int'(state), 3);
    idle(4, 1);
    tick(0, 0, 0, 0, 1, 0, 1);
    max_events = 16'd0;

    // Clear with a concurrent event, then async reset mid-run
    tick(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) rand_evt(0);
    check("t6_pre_count", int'(count), 5);
    tick(1, 16'h0042, 3'd2, 16'hBEEF, 1, 0, 1);
    check("t6_count", int'(count), 0);
    check("t6_m_valid", int'(m_valid), 0);
    check("t6_cap_cnt", int'(cap_cnt), 0);
    check("t6_overflow", int'(overflow), 0);
    check("t6_state", int'(state), 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 18; i++) rand_evt(0);
    #2 rst_n = 0;
    model_reset();
`ifdef SIMPLE16_TRACE_SHADOW_EN
    for (int i = 0; i < 8; i++) shadow_model[i] = 16'h0;
`endif
    #1;
    check("ar_state", int'(state), 0);
    check("ar_count", int'(count), 0);
    check("ar_m_valid", int'(m_valid), 0);
    check("ar_overflow", int'(overflow), 0);
    check("ar_drop_cnt", int'(drop_cnt), 0);
    check("ar_cap_cnt", int'(cap_cnt), 0);
    check("ar_m_wdata", int'(m_wdata), 0);
    #4 rst_n = 1;
    @(posedge clk); #1;

    // Randomized sessions
    for (int i = 0; i < 1500; i++) begin
      bit a_arm, clr;
      a_arm = ($urandom_range(0, 99) < 6);
      clr   = ($urandom_range(0, 99) < 2);
      if (a_arm && state == 2'd0) begin
        trig_en    = 1'($urandom);
        trig_pc    = 16'($urandom_range(0, 7));
        max_events = 16'($urandom_range(0, 24));
      end
      tick(1'($urandom), 16'($urandom_range(0, 7)), 3'($urandom), 16'($urandom),
           ($urandom_range(0, 99) < 45), a_arm, clr);
    end
    idle(40, 1);
    check("final_sb_empty", sbq.size(), 0);
    check("final_count", int'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/simple16_trace_buf.md
Name: simple16_trace_buf

Overview:
- Consumer end of the simple16_cpu observation port: captures register-write events (obs_reg_we, obs_reg_waddr, obs_reg_wdata, plus obs_pc) into an on-chip FIFO.
- Capture can be armed, triggered on a PC match, and limited to an event count.
- Events drain through a valid/ready stream for a host, UART bridge or bench.
- Sits beside the CPU on the same clock; the CPU is never stalled.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- obs_pc  in  16  CPU program counter for the current cycle.
- obs_reg_we  in  1  CPU register-file write strobe.
- obs_reg_waddr  in  3  register-file write address.
- obs_reg_wdata  in  16  register-file write data.
- arm  in  1  pulse; starts a capture session.
- clear  in  1  synchronous flush and return to IDLE.
- trig_en  in  1  1 = wait for PC match before capturing.
- trig_pc  in  16  trigger PC value.
- max_events  in  16  capture limit; 0 = unlimited.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts the head.
- m_pc  out  16  head entry PC.
- m_waddr  out  3  head entry register address.
- m_wdata  out  16  head entry write data.
- state  out  2  IDLE=0, ARMED=1, RUN=2, DONE=3.
- count  out  AW+1  FIFO occupancy.
- overflow  out  1  sticky: an event was dropped.
- drop_cnt  out  16  dropped events, saturating.
- cap_cnt  out  16  events written to the FIFO this session, saturating.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, FIFO empty, count=0, m_valid=0, overflow=0, drop_cnt=0, cap_cnt=0. m_pc, m_waddr and m_wdata are 0 while empty.
- Event: a cycle with obs_reg_we=1, sampled at the rising edge of clk.
- FSM:
  - IDLE: arm=1 -> ARMED if trig_en=1, else RUN.
  - ARMED: obs_pc==trig_pc -> RUN. An event in the matching cycle is captured (trigger inclusive).
  - RUN: an event is pushed if the FIFO is not full. When cap_cnt reaches max_events (max_events!=0) after a push -> DONE.
  - DONE: no capture. Draining continues.
  - arm is ignored outside IDLE.
- clear has priority over every other input and state. On clear: FIFO emptied, all counters and overflow zeroed, state=IDLE. A push or pop in the same cycle is discarded.
- Push latency: an event at edge N is visible at the FIFO head (m_valid=1) after edge N, provided the FIFO was empty.
- Output is first-word-fall-through; the head fields are valid whenever m_valid=1.
- Pop occurs on an edge with m_valid && m_ready. Head fields are stable while m_valid=1 and m_ready=0.
- Full FIFO with an event and a pop in the same cycle: both happen, count is unchanged, nothing is dropped.
- Full FIFO with an event and no pop: the event is dropped, overflow<=1, drop_cnt increments (saturates at 0xFFFF). cap_cnt is not incremented and the DONE check is unaffected.
- Empty FIFO with m_ready=1: no pop; pointers unchanged.
- Pointers are AW+1 bits and wrap modulo 2*DEPTH. Full/empty are derived from pointer MSB comparison. count = wr_ptr - rd_ptr.
- Events in IDLE, DONE, or ARMED without a match are ignored and are not counted as drops.
- cap_cnt saturates at 0xFFFF. With max_events=0, RUN continues indefinitely.
- If rst_n is asserted mid-session, all state is lost immediately (async). No partial entries remain.

Optional Feature:
- Macro: SIMPLE16_TRACE_SHADOW_EN.
- When defined:
  - Adds ports shadow_raddr in 3 and shadow_rdata out 16.
  - An 8x16 shadow register file is updated on every obs_reg_we, independent of FSM state, FIFO fullness and clear.
  - shadow_rdata is a combinational read of the selected register.
  - Shadow entries reset to 0.
- When undefined: the ports and storage do not exist, and behaviour is otherwise identical.

Test Plan:
1. trig_en=0, arm pulse, then 3 events (pc=4, r1=0x0005), (pc=5, r2=0x000A), (pc=6, r3=0x000F) with m_ready=1 -> heads popped in that order, each one cycle after its event; cap_cnt=3; state=RUN.
2. trig_en=1, trig_pc=0x0010, arm, events at pc 0x000E, 0x000F, 0x0010, 0x0011 -> state ARMED until pc=0x0010; only the pc 0x0010 and 0x0011 events are captured; cap_cnt=2.
3. DEPTH=16, m_ready=0, 20 events in RUN -> count=16, overflow=1, drop_cnt=4; draining returns the first 16 events in order.
4. FIFO full and m_ready=1 while an event arrives each cycle for 8 cycles -> count stays 16, drop_cnt stays 0, data order preserved.
5. max_events=2, trig_en=0, arm, 4 events -> state=DONE after the 2nd push; count=2; events 3 and 4 are ignored with drop_cnt=0; a new arm in DONE is ignored.
6. clear asserted with count=5 and a simultaneous event -> next cycle count=0, m_valid=0, cap_cnt=0, overflow=0, state=IDLE. Async rst_n=0 mid-RUN -> all outputs reset immediately.
